// File: rtl/cpu55_pkg.sv
// Shared cpu55 datapath types and constants used by decode, regfile and writeback.
package cpu55_pkg;

  localparam int unsigned REG_DW = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [4:0]  regaddr_t;
  typedef logic [31:0] word_t;

endpackage

// File: rtl/regfile_cell.sv
// One register-file entry: DW-bit register with load enable and asynchronous clear.
module regfile_cell #(
  parameter int unsigned DW = cpu55_pkg::REG_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (wen) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/regfile.sv
// cpu55 register file: 2^AW x DW, r0 hardwired to zero, two combinational read ports,
// one synchronous write port, optional write-to-read bypass and a saturating write counter.
module regfile
  import cpu55_pkg::*;
#(
  parameter int unsigned DW     = REG_DW,
  parameter int unsigned AW     = REG_AW,
  parameter int unsigned BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  output logic [15:0]   wr_count
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW-1:0] ZeroAddr = AW'(REG_ZERO);

  logic [DW-1:0] regs [Depth];
  logic          wr_valid;

  assign wr_valid = wen && (waddr != ZeroAddr);

  // r0 has no storage; its slot in the read array is a constant zero.
  assign regs[0] = '0;

  for (genvar i = 1; i < Depth; i++) begin : g_cell
    regfile_cell #(
      .DW (DW)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .wen (wen && (waddr == AW'(i))),
      .d   (wdata),
      .q   (regs[i])
    );
  end

  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == ZeroAddr) begin
      rdata1 = '0;
    end else if ((BYPASS != 0) && wen && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == ZeroAddr) begin
      rdata2 = '0;
    end else if ((BYPASS != 0) && wen && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
  end

  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_valid && (wr_count_q != 16'hffff)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: table-driven vectors through a scoreboard queue,
// plus hand-written reset, collision and counter-saturation sequences.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
  logic [15:0] wr_count, nb_wr_count;

  always #5 clk = ~clk;

  regfile #(.DW(32), .AW(5), .BYPASS(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .wr_count (wr_count)
  );

  regfile #(.DW(32), .AW(5), .BYPASS(0)) dut_nb (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr1   (raddr1),
    .rdata1   (nb_rdata1),
    .raddr2   (raddr2),
    .rdata2   (nb_rdata2),
    .wr_count (nb_wr_count)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [15:0] cnt;
  } exp_t;

  localparam int NumVec = 14;

  vec_t vecs [NumVec];
  exp_t exp_q [$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h, want %08h", name, act, req);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard: queue empty, got 0 entries, want 1");
    end else begin
      e = exp_q.pop_front();
      check($sformatf("vec%0d rdata1", e.idx), rdata1, e.e1);
      check($sformatf("vec%0d rdata2", e.idx), rdata2, e.e2);
      check($sformatf("vec%0d nb_rdata1", e.idx), nb_rdata1, e.n1);
      check($sformatf("vec%0d nb_rdata2", e.idx), nb_rdata2, e.n2);
      check($sformatf("vec%0d wr_count", e.idx), {16'h0, wr_count}, {16'h0, e.cnt});
      check($sformatf("vec%0d nb_wr_count", e.idx), {16'h0, nb_wr_count}, {16'h0, e.cnt});
    end
  endtask

  initial begin
    // Outputs are checked before the edge that commits each vector's write.
    //           wen   waddr  wdata          ra1    ra2    e1 (bypass)   e2            n1 (no byp)   n2            cnt
    vecs[0]  = '{1'b1, 5'd1,  32'hffffffff, 5'd1,  5'd2,  32'hffffffff, 32'h0,        32'h0,        32'h0,        16'd0};
    vecs[1]  = '{1'b1, 5'd2,  32'hffff0000, 5'd1,  5'd2,  32'hffffffff, 32'hffff0000, 32'hffffffff, 32'h0,        16'd1};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd2,  32'hffffffff, 32'hffff0000, 32'hffffffff, 32'hffff0000, 16'd2};
    vecs[3]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        16'd2};
    vecs[4]  = '{1'b0, 5'd0,  32'h12345678, 5'd0,  5'd1,  32'h0,        32'hffffffff, 32'h0,        32'hffffffff, 16'd2};
    vecs[5]  = '{1'b1, 5'd7,  32'h1,        5'd7,  5'd7,  32'h1,        32'h1,        32'h0,        32'h0,        16'd2};
    vecs[6]  = '{1'b1, 5'd7,  32'h2,        5'd7,  5'd7,  32'h2,        32'h2,        32'h1,        32'h1,        16'd3};
    vecs[7]  = '{1'b0, 5'd3,  32'haaaa5555, 5'd7,  5'd3,  32'h2,        32'h0,        32'h2,        32'h0,        16'd4};
    vecs[8]  = '{1'b0, 5'd3,  32'haaaa5555, 5'd7,  5'd3,  32'h2,        32'h0,        32'h2,        32'h0,        16'd4};
    vecs[9]  = '{1'b0, 5'd3,  32'haaaa5555, 5'd7,  5'd3,  32'h2,        32'h0,        32'h2,        32'h0,        16'd4};
    vecs[10] = '{1'b0, 5'd3,  32'haaaa5555, 5'd7,  5'd3,  32'h2,        32'h0,        32'h2,        32'h0,        16'd4};
    vecs[11] = '{1'b0, 5'd3,  32'haaaa5555, 5'd7,  5'd3,  32'h2,        32'h0,        32'h2,        32'h0,        16'd4};
    vecs[12] = '{1'b1, 5'd3,  32'h00c0ffee, 5'd3,  5'd1,  32'h00c0ffee, 32'hffffffff, 32'h0,        32'hffffffff, 16'd4};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd2,  32'h00c0ffee, 32'hffff0000, 32'h00c0ffee, 32'hffff0000, 16'd5};

    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = 5'd5; raddr2 = 5'd31;
    repeat (2) @(posedge clk);
    #1;
    check("reset rdata1", rdata1, 32'h0);
    check("reset rdata2", rdata2, 32'h0);
    check("reset wr_count", {16'h0, wr_count}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      raddr1 = vecs[i].ra1; raddr2 = vecs[i].ra2;
      exp_q.push_back('{i, vecs[i].e1, vecs[i].e2, vecs[i].n1, vecs[i].n2, vecs[i].cnt});
      @(negedge clk);
      sb_check();
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-run: clears storage without a clock edge.
    wen = 1'b1; waddr = 5'd5; wdata = 32'hdeadbeef;
    @(posedge clk);
    #1;
    wen = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    check("r5 before reset", rdata1, 32'hdeadbeef);
    rst = 1'b1;
    #1;
    check("r5 async reset", rdata1, 32'h0);
    check("r5 async reset nb", nb_rdata1, 32'h0);
    check("async reset wr_count", {16'h0, wr_count}, 32'h0);
    wen = 1'b1; waddr = 5'd5; wdata = 32'h00005555;
    #1;
    check("bypass in reset p1", rdata1, 32'h00005555);
    check("bypass in reset p2", rdata2, 32'h00005555);
    check("no bypass in reset", nb_rdata1, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; wen = 1'b0;
    #1;
    check("write ignored in reset", rdata1, 32'h0);
    check("write ignored in reset nb", nb_rdata2, 32'h0);
    check("wr_count after reset", {16'h0, wr_count}, 32'h0);

    // Reset held across the edge of a write: reset wins.
    wen = 1'b1; waddr = 5'd4; wdata = 32'h44444444; raddr1 = 5'd4;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; wen = 1'b0;
    #1;
    check("collision r4", rdata1, 32'h0);
    check("collision r4 nb", nb_rdata1, 32'h0);
    check("collision wr_count", {16'h0, wr_count}, 32'h0);

    // Counter saturation over 65536 valid writes.
    for (int i = 0; i < 65536; i++) begin
      wen = 1'b1; waddr = 5'((i % 31) + 1); wdata = i;
      @(posedge clk);
      #1;
      if (i == 65533) check("wr_count fffe", {16'h0, wr_count}, 32'h0000fffe);
      if (i == 65534) check("wr_count ffff", {16'h0, wr_count}, 32'h0000ffff);
    end
    wen = 1'b0; raddr1 = 5'((65535 % 31) + 1); raddr2 = 5'((65534 % 31) + 1);
    #1;
    check("wr_count saturated", {16'h0, wr_count}, 32'h0000ffff);
    check("nb wr_count saturated", {16'h0, nb_wr_count}, 32'h0000ffff);
    check("last write p1", rdata1, 32'd65535);
    check("prev write p2", rdata2, 32'd65534);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the cpu55 datapath: 32 × 32-bit registers, one synchronous write port and two combinational read ports. It sits between decode and the ALU: decode drives the read addresses, and writeback drives the write port. Register 0 is hardwired to zero. A parameter selects whether a read sees a same-cycle write to the same register.

## Interface
Parameters:
- `DW`, 32: data width in bits.
- `AW`, 5: address width; depth is 2^AW.
- `BYPASS`, 1: 1 means a read of the register being written returns `wdata` in the same cycle; 0 means it returns the old value.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset; clears every register to 0.
- `wen`, in, 1: write enable.
- `waddr`, in, AW: write address.
- `wdata`, in, DW: write data.
- `raddr1`, in, AW: read port 1 address.
- `rdata1`, out, DW: read port 1 data.
- `raddr2`, in, AW: read port 2 address.
- `rdata2`, out, DW: read port 2 data.
- `wr_count`, out, 16: count of committed writes to registers 1..31. Saturates at 16'hffff. Used for debug and coverage.

## Operation
- Storage is registers 1..31 (DW bits each). Register 0 has no storage.
- Write: on a rising `clk` with `wen`=1 and `waddr`≠0, `reg[waddr]` ← `wdata`, and `wr_count` increments unless it is saturated.
- A write with `waddr`=0 is silently dropped and does not increment `wr_count`.
- `wen`=0 leaves every register and `wr_count` unchanged.
- Read (each port independently, combinational):
  - If `raddr`=0, `rdata`=0, regardless of any write.
  - Else, if `BYPASS`=1, `wen`=1 and `waddr`=`raddr`, `rdata`=`wdata`.
  - Else, `rdata`=`reg[raddr]`.
- Both ports may read the same address. Both then return identical data, including the bypass case.
- Reset:
  - `rst`=1 clears all registers and `wr_count` to 0 immediately, without waiting for a clock edge.
  - While `rst` is held, writes are ignored.
  - Bypass still applies to the outputs while `rst` is held: `rdata` may show `wdata`, but nothing is stored.
- Reset asserted in the same cycle as a write: reset wins and the register stays 0.
- `wr_count` saturation: at 16'hffff a further valid write leaves it at 16'hffff.

## Timing
- Write latency is 1 cycle. Data written at edge N is visible on `rdata` (non-bypass path) after edge N.
- Read latency is 0 cycles; the path is combinational from `raddr` and the storage.
- When `BYPASS`=1 there is also a combinational path from `wdata`/`waddr`/`wen` to `rdata`.
- Reset values:
  - All storage = 0.
  - `rdata1` = `rdata2` = 0 for any address, unless bypass is active.
  - `wr_count` = 0.
- Release of `rst` is synchronous to design flow. The first write can occur at the first rising edge after deassertion.

## Structure
- Shared package `cpu55_pkg` holds:
  - `REG_ZERO` = 5'd0.
  - The `DW`/`AW` defaults.
  - The `regaddr_t` (5-bit) and `word_t` (32-bit) typedefs, which decode and writeback also use.
- One sub-module: `regfile_cell`, a DW-bit register with `clk`, `rst` (asynchronous, active-high, clears to 0), `wen`, `d`, `q`.
  - Instantiated 31 times via generate, for indices 1..31.
  - Each cell's `wen` = `wen` & (`waddr`==i).
- Read muxes, bypass compare, zero-forcing and `wr_count` are written in `regfile` itself.

## Test plan
- Reset:
  - Assert `rst` mid-simulation after writing 32'hdeadbeef to r5.
  - Required: `rdata1` (`raddr1`=5) reads 0 before the next clock edge, and `wr_count`=0.
- Basic write/read:
  - Write 32'hffffffff to r1, then 32'hffff0000 to r2 on consecutive cycles.
  - Then read `raddr1`=1, `raddr2`=2.
  - Required: 32'hffffffff and 32'hffff0000, and `wr_count`=2.
- Zero register:
  - Write 32'h12345678 to r0.
  - Required: `rdata1`(`raddr1`=0)=0 in that cycle and afterwards, and `wr_count` unchanged.
- Bypass:
  - With r7=32'h1, drive `wen`=1, `waddr`=7, `wdata`=32'h2, `raddr1`=`raddr2`=7.
  - Required: both ports read 32'h2 that cycle when `BYPASS`=1, and 32'h1 when `BYPASS`=0.
  - Required: both ports read 32'h2 after the edge in both builds.
- Write disabled:
  - Drive `wen`=0 with `waddr`=3, `wdata`=32'haaaa5555 for 5 cycles.
  - Required: r3 keeps its prior value and `wr_count` is unchanged.
- Reset vs write collision and saturation:
  - Assert `rst` at the same edge as a write to r4 → r4 reads 0.
  - Force 65536 valid writes → `wr_count` holds 16'hffff.
